// File: rtl/mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus
// Purpose  : Multicycle MIPS-I integer core (big-endian, no exceptions or
//            coprocessors) with one Avalon-style master port shared by
//            instruction fetch and data access. Execution starts at
//            RESET_VECTOR and halts when control transfers to address 0.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous, active-high reset
//            active       - 1 while running, 0 once halted
//            register_v0  - live value of GPR $2
//            address      - word-aligned byte address of current request
//            write / read - bus request strobes (never both high)
//            waitrequest  - slave stall, request held stable while high
//            writedata    - store data, lanes aligned to byteenable
//            byteenable   - byte-lane select, bit i covers bits [8i+7:8i]
//            readdata     - read data, valid the cycle after acceptance
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      state_q;
   logic [31:0] gpr_q [0:31];
   logic [31:0] pc_q, npc_q, nxt_q;   // current, delay-slot and following PC
   logic [31:0] ir_q, a_q, b_q, hi_q, lo_q, res_q, ea_q;
   logic [4:0]  dst_q;                // 0 means no register write-back
   logic        ld_q;
   logic        active_q, read_q, write_q;
   logic [31:0] address_q, writedata_q;
   logic [3:0]  be_q;

   assign active      = active_q;
   assign read        = read_q;
   assign write       = write_q;
   assign address     = address_q;
   assign writedata   = writedata_q;
   assign byteenable  = be_q;
   assign register_v0 = gpr_q[2];

   // ---------------------------------------------------------------------
   // Instruction fields and shared datapath values
   // ---------------------------------------------------------------------
   logic [5:0]  op, fn;
   logic [4:0]  rt, rd, sa;
   logic [31:0] simm, zimm, ea, link, btgt, quot_s, rem_s;
   logic [63:0] prod_s, prod_u;

   assign op     = ir_q[31:26];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign sa     = ir_q[10:6];
   assign fn     = ir_q[5:0];
   assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
   assign zimm   = {16'd0, ir_q[15:0]};
   assign ea     = a_q + simm;
   assign link   = pc_q + 32'd8;
   // Branch target is relative to the delay-slot address, i.e. npc_q
   assign btgt   = npc_q + {simm[29:0], 2'b00};
   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};
   assign quot_s = $signed(a_q) / $signed(b_q);
   assign rem_s  = $signed(a_q) % $signed(b_q);

   // ---------------------------------------------------------------------
   // Execute: result, destination, next PC, HI/LO and memory request
   // ---------------------------------------------------------------------
   logic [31:0] res_d, nxt_d, hi_d, lo_d, wd_d;
   logic [4:0]  dst_d;
   logic        mrd_d, mwr_d;
   logic [3:0]  be_d;

   always_comb begin
      res_d = 32'd0;
      dst_d = 5'd0;
      nxt_d = npc_q + 32'd4;
      hi_d  = hi_q;
      lo_d  = lo_q;
      mrd_d = 1'b0;
      mwr_d = 1'b0;
      be_d  = 4'b1111;
      wd_d  = b_q;
      case (op)
         6'h00: begin
            dst_d = rd;
            case (fn)
               6'h00: res_d = b_q << sa;
               6'h02: res_d = b_q >> sa;
               6'h03: res_d = $signed(b_q) >>> sa;
               6'h04: res_d = b_q << a_q[4:0];
               6'h06: res_d = b_q >> a_q[4:0];
               6'h07: res_d = $signed(b_q) >>> a_q[4:0];
               6'h08: begin nxt_d = a_q; dst_d = 5'd0; end
               6'h09: begin nxt_d = a_q; res_d = link; end
               6'h10: res_d = hi_q;
               6'h12: res_d = lo_q;
               6'h11: begin hi_d = a_q; dst_d = 5'd0; end
               6'h13: begin lo_d = a_q; dst_d = 5'd0; end
               6'h18: begin {hi_d, lo_d} = prod_s; dst_d = 5'd0; end
               6'h19: begin {hi_d, lo_d} = prod_u; dst_d = 5'd0; end
               6'h1A: begin
                  dst_d = 5'd0;
                  if (b_q != 32'd0) begin lo_d = quot_s; hi_d = rem_s; end
               end
               6'h1B: begin
                  dst_d = 5'd0;
                  if (b_q != 32'd0) begin lo_d = a_q / b_q; hi_d = a_q % b_q; end
               end
               6'h21: res_d = a_q + b_q;
               6'h23: res_d = a_q - b_q;
               6'h24: res_d = a_q & b_q;
               6'h25: res_d = a_q | b_q;
               6'h26: res_d = a_q ^ b_q;
               6'h2A: res_d = {31'd0, $signed(a_q) < $signed(b_q)};
               6'h2B: res_d = {31'd0, a_q < b_q};
               default: dst_d = 5'd0;
            endcase
         end
         6'h01: begin
            // REGIMM: rt[0] selects >=0 vs <0, rt[4] selects the link form
            if (rt[3:1] == 3'b000) begin
               if (rt[0] ? ~a_q[31] : a_q[31]) nxt_d = btgt;
               if (rt[4]) begin res_d = link; dst_d = 5'd31; end
            end
         end
         6'h02: nxt_d = {npc_q[31:28], ir_q[25:0], 2'b00};
         6'h03: begin
            nxt_d = {npc_q[31:28], ir_q[25:0], 2'b00};
            res_d = link;
            dst_d = 5'd31;
         end
         6'h04: if (a_q == b_q) nxt_d = btgt;
         6'h05: if (a_q != b_q) nxt_d = btgt;
         6'h06: if (a_q[31] || a_q == 32'd0) nxt_d = btgt;
         6'h07: if (!a_q[31] && a_q != 32'd0) nxt_d = btgt;
         6'h09: begin res_d = ea; dst_d = rt; end
         6'h0A: begin res_d = {31'd0, $signed(a_q) < $signed(simm)}; dst_d = rt; end
         6'h0B: begin res_d = {31'd0, a_q < simm}; dst_d = rt; end
         6'h0C: begin res_d = a_q & zimm; dst_d = rt; end
         6'h0D: begin res_d = a_q | zimm; dst_d = rt; end
         6'h0E: begin res_d = a_q ^ zimm; dst_d = rt; end
         6'h0F: begin res_d = {ir_q[15:0], 16'd0}; dst_d = rt; end
         6'h20, 6'h24: begin mrd_d = 1'b1; dst_d = rt; be_d = 4'b1000 >> ea[1:0]; end
         6'h21, 6'h25: begin mrd_d = 1'b1; dst_d = rt; be_d = ea[1] ? 4'b0011 : 4'b1100; end
         6'h22, 6'h23, 6'h26: begin mrd_d = 1'b1; dst_d = rt; end
         6'h28: begin mwr_d = 1'b1; be_d = 4'b1000 >> ea[1:0]; wd_d = {4{b_q[7:0]}}; end
         6'h29: begin mwr_d = 1'b1; be_d = ea[1] ? 4'b0011 : 4'b1100; wd_d = {2{b_q[15:0]}}; end
         6'h2B: mwr_d = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Load alignment: big-endian, byte offset 0 lives in bits [31:24]
   // ---------------------------------------------------------------------
   logic [7:0]  lane;
   logic [15:0] half;
   logic [31:0] load_val;

   always_comb begin
      lane     = readdata[{~ea_q[1:0], 3'b000} +: 8];
      half     = ea_q[1] ? readdata[15:0] : readdata[31:16];
      load_val = readdata;
      case (op)
         6'h20: load_val = {{24{lane[7]}}, lane};
         6'h24: load_val = {24'd0, lane};
         6'h21: load_val = {{16{half[15]}}, half};
         6'h25: load_val = {16'd0, half};
         6'h22: begin
            case (ea_q[1:0])
               2'd0:    load_val = readdata;
               2'd1:    load_val = {readdata[23:0], b_q[7:0]};
               2'd2:    load_val = {readdata[15:0], b_q[15:0]};
               default: load_val = {readdata[7:0],  b_q[23:0]};
            endcase
         end
         6'h26: begin
            case (ea_q[1:0])
               2'd0:    load_val = {b_q[31:8],  readdata[31:24]};
               2'd1:    load_val = {b_q[31:16], readdata[31:16]};
               2'd2:    load_val = {b_q[31:24], readdata[31:8]};
               default: load_val = readdata;
            endcase
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control FSM and architectural state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_VECTOR;
         npc_q       <= RESET_VECTOR + 32'd4;
         nxt_q       <= 32'd0;
         ir_q        <= 32'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         res_q       <= 32'd0;
         ea_q        <= 32'd0;
         dst_q       <= 5'd0;
         ld_q        <= 1'b0;
         active_q    <= 1'b1;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= 32'd0;
         writedata_q <= 32'd0;
         be_q        <= 4'b0000;
         for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
      end else begin
         case (state_q)
            S_FETCH: begin
               // Only the first fetch after reset needs to raise the request
               // here; later fetches are launched from write-back.
               if (!read_q) begin
                  read_q    <= 1'b1;
                  address_q <= pc_q;
                  be_q      <= 4'b1111;
               end else if (!waitrequest) begin
                  read_q  <= 1'b0;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               ir_q    <= readdata;
               a_q     <= gpr_q[readdata[25:21]];
               b_q     <= gpr_q[readdata[20:16]];
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               res_q <= res_d;
               dst_q <= dst_d;
               nxt_q <= nxt_d;
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               ea_q  <= ea;
               ld_q  <= mrd_d;
               if (mrd_d || mwr_d) begin
                  read_q      <= mrd_d;
                  write_q     <= mwr_d;
                  address_q   <= {ea[31:2], 2'b00};
                  be_q        <= be_d;
                  writedata_q <= wd_d;
                  state_q     <= S_MEM;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (!waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= S_WB;
               end
            end
            S_WB: begin
               if (dst_q != 5'd0) gpr_q[dst_q] <= ld_q ? load_val : res_q;
               pc_q  <= npc_q;
               npc_q <= nxt_q;
               if (npc_q == 32'd0) begin
                  active_q <= 1'b0;
                  be_q     <= 4'b0000;
                  state_q  <= S_HALT;
               end else begin
                  read_q    <= 1'b1;
                  address_q <= npc_q;
                  be_q      <= 4'b1111;
                  state_q   <= S_FETCH;
               end
            end
            S_HALT: ;
            default: state_q <= S_HALT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_bus
// Purpose  : Directed self-checking bench for mips_cpu_bus. Small programs
//            are placed in a boot ROM at 0xBFC00000 and a RAM at 0x00000000;
//            each ends with jr $0 and the final $v0 / halt state is checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus;

   logic        clk = 1'b0;
   logic        reset;
   logic        active, write, read, waitrequest;
   logic [31:0] register_v0, address, writedata, readdata;
   logic [3:0]  byteenable;

   int checks   = 0;
   int failures = 0;

   mips_cpu_bus dut (
      .clk         (clk),
      .reset       (reset),
      .active      (active),
      .register_v0 (register_v0),
      .address     (address),
      .write       (write),
      .read        (read),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata)
   );

   always #5 clk = ~clk;

   // ---------------- memory slave model ----------------
   logic [31:0] rom [0:255];
   logic [31:0] ram [0:255];
   logic [1:0]  stall = 2'd0;
   bit          rnd_en = 1'b0;

   assign waitrequest = (stall != 2'd0);

   always @(posedge clk) begin
      if (reset) begin
         stall <= 2'd0;
      end else if (read || write) begin
         if (stall != 2'd0) begin
            stall <= stall - 2'd1;
         end else begin
            stall <= rnd_en ? 2'($urandom_range(0, 3)) : 2'd0;
            if (read)
               readdata <= address[31] ? rom[address[9:2]] : ram[address[9:2]];
            if (write && !address[31])
               for (int b = 0; b < 4; b++)
                  if (byteenable[b]) ram[address[9:2]][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   // ---------------- bus protocol monitor ----------------
   bit          bad_rw = 1'b0, bad_align = 1'b0, bad_hold = 1'b0, held = 1'b0;
   logic [69:0] snap;

   always @(posedge clk) begin
      if (read && write) bad_rw <= 1'b1;
      if ((read || write) && address[1:0] != 2'b00) bad_align <= 1'b1;
      if (held && !reset && {read, write, address, byteenable, writedata} != snap) bad_hold <= 1'b1;
      held <= (read || write) && waitrequest && !reset;
      snap <= {read, write, address, byteenable, writedata};
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] fi(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] fr(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   localparam logic [31:0] JR0 = 32'h0000_0008;
   localparam logic [31:0] NOP = 32'h0000_0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         rom[i] = NOP;
         ram[i] = 32'd0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input logic [31:0] exp_v0);
      int cyc = 0;
      while (active === 1'b1 && cyc < 10000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_halt"}, {31'd0, active}, 32'd0);
      check({tag, "_v0"}, register_v0, exp_v0);
   endtask

   task automatic run(input string tag, input logic [31:0] exp_v0, input bit rnd);
      rnd_en = rnd;
      do_reset();
      wait_halt(tag, exp_v0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      reset = 1'b1;

      // bgezal taken, delay slot executes, target does jr $0 / lui $2
      clear_mem();
      rom[0]  = fi(6'h0F, 0, 8, 16'hBFC0);      // lui   $8,0xBFC0
      rom[1]  = fi(6'h23, 8, 9, 16'h002C);      // lw    $9,0x2C($8)
      rom[2]  = fi(6'h01, 9, 5'h11, 16'h0004);  // bgezal $9,+4
      rom[3]  = NOP;
      rom[4]  = fi(6'h09, 0, 2, 16'h0055);      // skipped
      rom[5]  = fi(6'h09, 0, 2, 16'h0066);      // skipped
      rom[6]  = fi(6'h09, 0, 2, 16'h0077);      // skipped
      rom[7]  = JR0;
      rom[8]  = fi(6'h0F, 0, 2, 16'hFFFF);      // lui   $2,0xFFFF
      rom[11] = 32'd10;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_active", {31'd0, active}, 32'd1);
      check("rst_read",   {31'd0, read},   32'd0);
      check("rst_write",  {31'd0, write},  32'd0);
      check("rst_be",     {28'd0, byteenable}, 32'd0);
      check("rst_v0",     register_v0, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("active_after_rst", {31'd0, active}, 32'd1);
      cyc = 0;
      while (read !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("first_read", {31'd0, read}, 32'd1);
      check("first_addr", address, 32'hBFC00000);
      wait_halt("bgezal", 32'hFFFF0000);
      check("halt_read", {31'd0, read}, 32'd0);

      // bgezal link value ($31 = PC+8)
      rom[8] = fr(31, 0, 2, 0, 6'h21);           // addu $2,$31,$0
      run("bgezal_link", 32'hBFC00010, 1'b0);

      // sltu after addiu -1
      clear_mem();
      rom[0] = fi(6'h09, 0, 2, 16'hFFFF);       // addiu $2,$0,-1
      rom[1] = fr(0, 2, 2, 0, 6'h2B);           // sltu  $2,$0,$2
      rom[2] = JR0;
      run("sltu", 32'h00000001, 1'b0);

      // slt signed: -1 < 0
      rom[0] = fi(6'h09, 0, 3, 16'hFFFF);       // addiu $3,$0,-1
      rom[1] = fr(3, 0, 2, 0, 6'h2A);           // slt   $2,$3,$0
      run("slt", 32'h00000001, 1'b0);

      // sra / srlv (shift amount from rs[4:0] of 36 = 4)
      clear_mem();
      rom[0] = fi(6'h0F, 0, 3, 16'h8000);       // lui   $3,0x8000
      rom[1] = fr(0, 3, 2, 4, 6'h03);           // sra   $2,$3,4
      rom[2] = JR0;
      run("sra", 32'hF8000000, 1'b0);
      rom[1] = fi(6'h09, 0, 4, 16'd36);         // addiu $4,$0,36
      rom[2] = fr(4, 3, 2, 0, 6'h06);           // srlv  $2,$3,$4
      rom[3] = JR0;
      run("srlv", 32'h08000000, 1'b0);

      // mult -6*7
      clear_mem();
      rom[0] = fi(6'h09, 0, 4, 16'hFFFA);       // addiu $4,$0,-6
      rom[1] = fi(6'h09, 0, 5, 16'd7);          // addiu $5,$0,7
      rom[2] = fr(4, 5, 0, 0, 6'h18);           // mult  $4,$5
      rom[3] = fr(0, 0, 2, 0, 6'h12);           // mflo  $2
      rom[4] = JR0;
      run("mult_lo", 32'hFFFFFFD6, 1'b0);
      run("mult_lo_stall", 32'hFFFFFFD6, 1'b1);
      rom[3] = fr(0, 0, 2, 0, 6'h10);           // mfhi  $2
      run("mult_hi", 32'hFFFFFFFF, 1'b0);

      // div 7/-2
      rom[0] = fi(6'h09, 0, 4, 16'd7);
      rom[1] = fi(6'h09, 0, 5, 16'hFFFE);
      rom[2] = fr(4, 5, 0, 0, 6'h1A);           // div   $4,$5
      rom[3] = fr(0, 0, 2, 0, 6'h12);
      run("div_lo", 32'hFFFFFFFD, 1'b0);
      rom[3] = fr(0, 0, 2, 0, 6'h10);
      run("div_hi", 32'h00000001, 1'b0);

      // divide by zero leaves HI unchanged
      rom[0] = fi(6'h09, 0, 4, 16'd5);
      rom[1] = fr(4, 0, 0, 0, 6'h11);           // mthi  $4
      rom[2] = fr(4, 0, 0, 0, 6'h1A);           // div   $4,$0
      rom[3] = fr(0, 0, 2, 0, 6'h10);
      run("div0_hi", 32'h00000005, 1'b0);

      // sb at EA[1:0]=1, read back via lbu / lb
      clear_mem();
      rom[0] = fi(6'h09, 0, 8, 16'h0100);       // addiu $8,$0,0x100
      rom[1] = fi(6'h09, 0, 9, 16'h00AB);       // addiu $9,$0,0xAB
      rom[2] = fi(6'h28, 8, 9, 16'd1);          // sb    $9,1($8)
      rom[3] = fi(6'h24, 8, 2, 16'd1);          // lbu   $2,1($8)
      rom[4] = JR0;
      run("sb_lbu", 32'h000000AB, 1'b0);
      check("sb_ram", ram[64], 32'h00AB0000);
      ram[64] = 32'd0;
      run("sb_lbu_stall", 32'h000000AB, 1'b1);
      check("sb_ram_stall", ram[64], 32'h00AB0000);
      rom[3] = fi(6'h20, 8, 2, 16'd1);          // lb    $2,1($8)
      run("sb_lb", 32'hFFFFFFAB, 1'b0);

      // sh at EA[1:0]=2, lhu back
      ram[64] = 32'd0;
      rom[1] = fi(6'h09, 0, 9, 16'h1234);
      rom[2] = fi(6'h29, 8, 9, 16'd2);          // sh    $9,2($8)
      rom[3] = fi(6'h25, 8, 2, 16'd2);          // lhu   $2,2($8)
      run("sh_lhu", 32'h00001234, 1'b0);
      check("sh_ram", ram[64], 32'h00001234);

      // lwl / lwr at EA[1:0]=1 merging into 0xAABBCCDD
      clear_mem();
      ram[64] = 32'h11223344;
      rom[0] = fi(6'h09, 0, 8, 16'h0100);
      rom[1] = fi(6'h0F, 0, 2, 16'hAABB);       // lui   $2,0xAABB
      rom[2] = fi(6'h0D, 2, 2, 16'hCCDD);       // ori   $2,$2,0xCCDD
      rom[3] = fi(6'h22, 8, 2, 16'd1);          // lwl   $2,1($8)
      rom[4] = JR0;
      run("lwl", 32'h223344DD, 1'b0);
      rom[3] = fi(6'h26, 8, 2, 16'd1);          // lwr   $2,1($8)
      run("lwr", 32'hAABB1122, 1'b0);

      // beq taken: delay slot runs, next instruction skipped
      clear_mem();
      rom[0] = fi(6'h09, 0, 2, 16'd1);
      rom[1] = fi(6'h04, 0, 0, 16'd2);          // beq   $0,$0,+2
      rom[2] = fi(6'h09, 2, 2, 16'd2);          // delay slot
      rom[3] = fi(6'h09, 2, 2, 16'd4);          // skipped
      rom[4] = JR0;
      run("beq_taken", 32'h00000003, 1'b0);
      rom[1] = fi(6'h05, 0, 0, 16'd2);          // bne   $0,$0,+2 (not taken)
      run("bne_fall", 32'h00000007, 1'b0);

      // jal links PC+8
      clear_mem();
      rom[0] = {6'h03, 26'h3F00004};            // jal   0xBFC00010
      rom[2] = JR0;                             // skipped
      rom[4] = fr(31, 0, 2, 0, 6'h21);          // addu  $2,$31,$0
      rom[5] = JR0;
      run("jal_link", 32'hBFC00008, 1'b0);

      check("bus_rw_excl", {31'd0, bad_rw},    32'd0);
      check("bus_align",   {31'd0, bad_align}, 32'd0);
      check("bus_hold",    {31'd0, bad_hold},  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
